control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised hardwired control unit that steps the datapath through the T0–T7 timing phases of each instruction. It issues the register, memory and ALU strobes the datapath consumes, one state per clock. It supports memory wait states and free-running instruction execution. It sits beside the datapath and replaces hand-driven control sequences in benches and at the top level.

## Interface

**Parameters**
- `DATA_W`, 32: IR width.
- `OPC_W`, 5: opcode width. Opcode is `ir[DATA_W-1 -: OPC_W]`.
- `STEP_W`, 4: width of the `step` output.

**Ports**
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `clear`, in, 1: reset, synchronous and active-high.
- `run`, in, 1: start or continue execution.
- `mem_ready`, in, 1: memory completion handshake.
- `ir`, in, DATA_W: current instruction register contents.
- `PCout`, `MARin`, `IncPC`, `Zin`, `Zlowout`, `PCin`, `Read`, `Write`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Cout`, `BAout`, `Gra`, `Grb`, `Grc`, `Rin`, `Rout`: out, 1 each; datapath strobes.
- `alu_op`, out, OPC_W: ALU operation select.
- `step`, out, STEP_W: current state encoding.
- `busy`, out, 1: high in any state other than IDLE or HALT.
- `done`, out, 1: one-cycle pulse in the final step of each instruction.
- `halted`, out, 1: high while in HALT.

## Operation

**States:** IDLE, T0–T7, HALT. Outputs are Moore (a function of state and the registered opcode), valid for the whole cycle.

**Fetch (all instructions):**
- T0: `PCout MARin IncPC Zin`.
- T1: `Zlowout PCin Read MDRin`.
- T2: `MDRout IRin`.
- Opcode is registered on the T2→T3 edge from `ir`.

**Execute:**
- `ld` (00000):
  - T3: `Grb BAout Yin`.
  - T4: `Cout Zin`, `alu_op`=ADD.
  - T5: `Zlowout MARin`.
  - T6: `Read MDRin`.
  - T7: `MDRout Gra Rin`, `done`.
- `ldi` (00001):
  - T3 and T4 as `ld`.
  - T5: `Zlowout Gra Rin`, `done`.
- `st` (00010):
  - T3–T5 as `ld`.
  - T6: `Gra Rout MDRin`.
  - T7: `Write`, `done`.
- ALU ops (00011–01100):
  - T3: `Grb Rout Yin`.
  - T4: `Grc Rout Zin`, `alu_op`=opcode.
  - T5: `Zlowout Gra Rin`, `done`.
- `halt` (11011): T3 → HALT with `done`.
- Any other opcode: no-op; T3 asserts `done` only.
- ADD code is opcode 00011. `alu_op`=0 whenever the ALU is unused.

**Transitions:**
- IDLE→T0 when `run`=1.
- After the `done` step: →T0 if `run`=1, else →IDLE.
- HALT is left only by `clear`.
- `run` is ignored outside IDLE and the `done` step.

**Boundary conditions:**
- `clear` in any state, including mid-wait: next state is IDLE; all strobes, `alu_op`, `done` and `halted` are 0 and the registered opcode is 0.
- `mem_ready` in non-memory states: ignored.
- Simultaneous `clear` and `run`: `clear` wins.

## Timing

- Reset value: every output 0, `step`=IDLE.
- Latency from `run` to the first T0: 1 cycle.
- With `mem_ready` tied high, from T0 to `done`:
  - `ld` and `st`: 8 cycles.
  - `ldi` and ALU ops: 6 cycles.
  - No-op: 4 cycles.
- Back-to-back instructions have zero idle cycles.
- Memory handshake (T1, `ld`/T6, `st`/T7):
  - The state holds with its strobes asserted until a rising edge samples `mem_ready`=1, then advances.
  - Each cycle of low `mem_ready` adds exactly one cycle.

## Configuration

- `SEQ_MEM_WAIT_EN`
  - Defined: the memory handshake above is implemented.
  - Undefined: `mem_ready` is unused and memory states last exactly one cycle, matching fixed-latency memory.

## Structure

- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants (`OP_LD`, `OP_LDI`, `OP_ST`, `OP_ADD`…`OP_HALT`);
  - the state enumeration (IDLE, T0–T7, HALT);
  - the control-bundle struct type.
- One sub-module, `control_decode`, is natural: a combinational map from (state, opcode) to the control bundle.
- The top holds the state register, opcode register and handshake logic.

## Test plan

- Reset, then `run`=1, `ir`=32'h0088_0005 (`ld`), `mem_ready`=1:
  - strobes follow T0–T7 exactly, `alu_op`=00011 in T4;
  - `done` at cycle 8, then IDLE with `run`=0.
- `ir` opcode 00010 (`st`), `mem_ready` low for 3 cycles in T7: `Write` is held 4 cycles and `done` comes at cycle 11.
- Opcode 00100 then 00001 with `run` held high: second T0 directly follows the first `done`, and `done` pulses at cycles 6 and 12.
- Assert `clear` in T6 of `ld` while `mem_ready`=0: the next cycle shows IDLE with all outputs 0.
- Opcode 11011: `halted`=1 after T3; `run` toggling has no effect until `clear`.
- `SEQ_MEM_WAIT_EN` undefined, `mem_ready`=0 throughout: `ld` still completes in 8 cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer states
// and the control bundle the decoder produces.
package cpu_ctrl_pkg;

   localparam int unsigned OP_LD       = 0;
   localparam int unsigned OP_LDI      = 1;
   localparam int unsigned OP_ST       = 2;
   localparam int unsigned OP_ADD      = 3;
   localparam int unsigned OP_SUB      = 4;
   localparam int unsigned OP_AND      = 5;
   localparam int unsigned OP_OR       = 6;
   localparam int unsigned OP_SHR      = 7;
   localparam int unsigned OP_SHRA     = 8;
   localparam int unsigned OP_SHL      = 9;
   localparam int unsigned OP_ROR      = 10;
   localparam int unsigned OP_ROL      = 11;
   localparam int unsigned OP_MUL      = 12;
   localparam int unsigned OP_ALU_LAST = OP_MUL;
   localparam int unsigned OP_HALT     = 27;

   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StT0   = 4'd1,
      StT1   = 4'd2,
      StT2   = 4'd3,
      StT3   = 4'd4,
      StT4   = 4'd5,
      StT5   = 4'd6,
      StT6   = 4'd7,
      StT7   = 4'd8,
      StHalt = 4'd9
   } state_e;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic z_in;
      logic zlow_out;
      logic pc_in;
      logic read;
      logic write;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic c_out;
      logic ba_out;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic mem_wait; // state waits on the memory handshake
      logic done;     // final step of the instruction
   } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational map from (state, registered opcode) to the datapath control
// bundle and ALU select.
module control_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPC_W = 5
) (
   input  state_e           state_i,
   input  logic [OPC_W-1:0] opc_i,
   output ctrl_t            ctrl_o,
   output logic [OPC_W-1:0] alu_op_o
);

   logic is_ld, is_ldi, is_st, is_alu, is_ls;

   assign is_ld  = (opc_i == OPC_W'(OP_LD));
   assign is_ldi = (opc_i == OPC_W'(OP_LDI));
   assign is_st  = (opc_i == OPC_W'(OP_ST));
   assign is_alu = (opc_i >= OPC_W'(OP_ADD)) && (opc_i <= OPC_W'(OP_ALU_LAST));
   // ld/ldi/st share the base+offset address calculation in T3-T4
   assign is_ls  = is_ld | is_ldi | is_st;

   always_comb begin
      ctrl_o   = '0;
      alu_op_o = '0;
      case (state_i)
         StT0: begin
            ctrl_o.pc_out = 1'b1;
            ctrl_o.mar_in = 1'b1;
            ctrl_o.inc_pc = 1'b1;
            ctrl_o.z_in   = 1'b1;
         end
         StT1: begin
            ctrl_o.zlow_out = 1'b1;
            ctrl_o.pc_in    = 1'b1;
            ctrl_o.read     = 1'b1;
            ctrl_o.mdr_in   = 1'b1;
            ctrl_o.mem_wait = 1'b1;
         end
         StT2: begin
            ctrl_o.mdr_out = 1'b1;
            ctrl_o.ir_in   = 1'b1;
         end
         StT3: begin
            if (is_ls) begin
               ctrl_o.grb    = 1'b1;
               ctrl_o.ba_out = 1'b1;
               ctrl_o.y_in   = 1'b1;
            end else if (is_alu) begin
               ctrl_o.grb   = 1'b1;
               ctrl_o.r_out = 1'b1;
               ctrl_o.y_in  = 1'b1;
            end else begin
               ctrl_o.done = 1'b1; // halt and no-op end here
            end
         end
         StT4: begin
            if (is_ls) begin
               ctrl_o.c_out = 1'b1;
               ctrl_o.z_in  = 1'b1;
               alu_op_o     = OPC_W'(OP_ADD);
            end else if (is_alu) begin
               ctrl_o.grc   = 1'b1;
               ctrl_o.r_out = 1'b1;
               ctrl_o.z_in  = 1'b1;
               alu_op_o     = opc_i;
            end
         end
         StT5: begin
            if (is_ld || is_st) begin
               ctrl_o.zlow_out = 1'b1;
               ctrl_o.mar_in   = 1'b1;
            end else if (is_ldi || is_alu) begin
               ctrl_o.zlow_out = 1'b1;
               ctrl_o.gra      = 1'b1;
               ctrl_o.r_in     = 1'b1;
               ctrl_o.done     = 1'b1;
            end
         end
         StT6: begin
            if (is_ld) begin
               ctrl_o.read     = 1'b1;
               ctrl_o.mdr_in   = 1'b1;
               ctrl_o.mem_wait = 1'b1;
            end else if (is_st) begin
               ctrl_o.gra    = 1'b1;
               ctrl_o.r_out  = 1'b1;
               ctrl_o.mdr_in = 1'b1;
            end
         end
         StT7: begin
            if (is_ld) begin
               ctrl_o.mdr_out = 1'b1;
               ctrl_o.gra     = 1'b1;
               ctrl_o.r_in    = 1'b1;
               ctrl_o.done    = 1'b1;
            end else if (is_st) begin
               ctrl_o.write    = 1'b1;
               ctrl_o.done     = 1'b1;
               ctrl_o.mem_wait = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T7 control sequencer: state and opcode registers plus memory handshake.
// Define SEQ_MEM_WAIT_EN to stall memory states until mem_ready is sampled high.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OPC_W  = 5,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              run,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir,
   output logic              PCout,
   output logic              MARin,
   output logic              IncPC,
   output logic              Zin,
   output logic              Zlowout,
   output logic              PCin,
   output logic              Read,
   output logic              Write,
   output logic              MDRin,
   output logic              MDRout,
   output logic              IRin,
   output logic              Yin,
   output logic              Cout,
   output logic              BAout,
   output logic              Gra,
   output logic              Grb,
   output logic              Grc,
   output logic              Rin,
   output logic              Rout,
   output logic [OPC_W-1:0]  alu_op,
   output logic [STEP_W-1:0] step,
   output logic              busy,
   output logic              done,
   output logic              halted
);

   state_e           state_q, state_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   ctrl_t            ctrl;
   logic             advance;
   logic             unused_sig;

   control_decode #(
      .OPC_W (OPC_W)
   ) u_decode (
      .state_i  (state_q),
      .opc_i    (opc_q),
      .ctrl_o   (ctrl),
      .alu_op_o (alu_op)
   );

`ifdef SEQ_MEM_WAIT_EN
   assign advance    = ~ctrl.mem_wait | mem_ready;
   assign unused_sig = ^ir[DATA_W-OPC_W-1:0];
`else
   assign advance    = 1'b1;
   assign unused_sig = ^{mem_ready, ctrl.mem_wait, ir[DATA_W-OPC_W-1:0]};
`endif

   always_comb begin
      opc_d   = (state_q == StT2) ? ir[DATA_W-1 -: OPC_W] : opc_q;
      state_d = state_q;
      case (state_q)
         StIdle: if (run) state_d = StT0;
         StHalt: state_d = StHalt;
         default: begin
            if (advance) begin
               if (ctrl.done) begin
                  if (opc_q == OPC_W'(OP_HALT)) state_d = StHalt;
                  else                          state_d = run ? StT0 : StIdle;
               end else begin
                  state_d = state_e'(state_q + 4'd1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= StIdle;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
      end
   end

   assign PCout   = ctrl.pc_out;
   assign MARin   = ctrl.mar_in;
   assign IncPC   = ctrl.inc_pc;
   assign Zin     = ctrl.z_in;
   assign Zlowout = ctrl.zlow_out;
   assign PCin    = ctrl.pc_in;
   assign Read    = ctrl.read;
   assign Write   = ctrl.write;
   assign MDRin   = ctrl.mdr_in;
   assign MDRout  = ctrl.mdr_out;
   assign IRin    = ctrl.ir_in;
   assign Yin     = ctrl.y_in;
   assign Cout    = ctrl.c_out;
   assign BAout   = ctrl.ba_out;
   assign Gra     = ctrl.gra;
   assign Grb     = ctrl.grb;
   assign Grc     = ctrl.grc;
   assign Rin     = ctrl.r_in;
   assign Rout    = ctrl.r_out;
   // a stalled memory step only counts as final on the cycle it completes
   assign done    = ctrl.done & advance;
   assign step    = STEP_W'(state_q);
   assign busy    = (state_q != StIdle) && (state_q != StHalt);
   assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expected output words are
// queued per cycle and compared against the packed DUT outputs.
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   logic        clock     = 1'b0;
   logic        clear     = 1'b1;
   logic        run       = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir        = '0;
   logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout;
   logic IRin, Yin, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
   logic [4:0] alu_op;
   logic [3:0] step;
   logic       busy, done, halted;

   always #5 clock = ~clock;

   control_sequencer #(
      .DATA_W (32),
      .OPC_W  (5),
      .STEP_W (4)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .run       (run),
      .mem_ready (mem_ready),
      .ir        (ir),
      .PCout     (PCout),
      .MARin     (MARin),
      .IncPC     (IncPC),
      .Zin       (Zin),
      .Zlowout   (Zlowout),
      .PCin      (PCin),
      .Read      (Read),
      .Write     (Write),
      .MDRin     (MDRin),
      .MDRout    (MDRout),
      .IRin      (IRin),
      .Yin       (Yin),
      .Cout      (Cout),
      .BAout     (BAout),
      .Gra       (Gra),
      .Grb       (Grb),
      .Grc       (Grc),
      .Rin       (Rin),
      .Rout      (Rout),
      .alu_op    (alu_op),
      .step      (step),
      .busy      (busy),
      .done      (done),
      .halted    (halted)
   );

   localparam logic [18:0] PCO = 19'h40000, MAI = 19'h20000, INC = 19'h10000;
   localparam logic [18:0] ZI  = 19'h08000, ZLO = 19'h04000, PCI = 19'h02000;
   localparam logic [18:0] RD  = 19'h01000, WR  = 19'h00800, MDI = 19'h00400;
   localparam logic [18:0] MDO = 19'h00200, IRI = 19'h00100, YI  = 19'h00080;
   localparam logic [18:0] CO  = 19'h00040, BAO = 19'h00020, GRA = 19'h00010;
   localparam logic [18:0] GRB = 19'h00008, GRC = 19'h00004, RI  = 19'h00002;
   localparam logic [18:0] RO  = 19'h00001, NONE = 19'h00000;

   localparam logic [31:0] IR_LD   = 32'h0088_0005;
   localparam logic [31:0] IR_LDI  = 32'h0800_0000;
   localparam logic [31:0] IR_ST   = 32'h1000_0000;
   localparam logic [31:0] IR_SUB  = 32'h2000_0000;
   localparam logic [31:0] IR_HALT = 32'hD800_0000;
   localparam logic [31:0] IR_NOP  = 32'hF800_0000;

   typedef struct {
      string       tag;
      logic [30:0] v;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [30:0] obs;

   assign obs = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
                 IRin, Yin, Cout, BAout, Gra, Grb, Grc, Rin, Rout,
                 alu_op, step, busy, done, halted};

   task automatic push(input string tag, input logic [18:0] s, input logic [4:0] a,
                       input logic [3:0] st, input logic b, input logic d, input logic h);
      exp_t e;
      e.tag = tag;
      e.v   = {s, a, st, b, d, h};
      sb.push_back(e);
   endtask

   task automatic exp_run(input string tag, input logic [3:0] st, input logic [18:0] s,
                          input logic [4:0] a, input logic d);
      push(tag, s, a, st, 1'b1, d, 1'b0);
   endtask

   task automatic exp_idle(input string tag);
      push(tag, NONE, 5'd0, StIdle, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic exp_halt(input string tag);
      push(tag, NONE, 5'd0, StHalt, 1'b0, 1'b0, 1'b1);
   endtask

   // One clock: after the edge, drive this cycle's inputs, then compare.
   task automatic cyc(input logic r, input logic mr, input logic clr);
      exp_t e;
      @(posedge clock);
      #1;
      run       = r;
      mem_ready = mr;
      clear     = clr;
      #1;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: got %h required a queued expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic fetch(input string nm, input logic r);
      exp_run({nm, "_t0"}, StT0, PCO | MAI | INC | ZI, 5'd0, 1'b0); cyc(r, 1'b1, 1'b0);
      exp_run({nm, "_t1"}, StT1, ZLO | PCI | RD | MDI, 5'd0, 1'b0); cyc(r, 1'b1, 1'b0);
      exp_run({nm, "_t2"}, StT2, MDO | IRI, 5'd0, 1'b0);           cyc(r, 1'b1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ir = IR_LD;
      exp_idle("reset");      cyc(1'b1, 1'b1, 1'b1);
      exp_idle("clear_wins"); cyc(1'b1, 1'b1, 1'b0);

      // ld with mem_ready high, run dropped so it returns to IDLE
      fetch("ld", 1'b0);
      exp_run("ld_t3", StT3, GRB | BAO | YI, 5'd0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
      exp_run("ld_t4", StT4, CO | ZI, 5'd3, 1'b0);        cyc(1'b0, 1'b1, 1'b0);
      exp_run("ld_t5", StT5, ZLO | MAI, 5'd0, 1'b0);      cyc(1'b0, 1'b1, 1'b0);
      exp_run("ld_t6", StT6, RD | MDI, 5'd0, 1'b0);       cyc(1'b0, 1'b1, 1'b0);
      exp_run("ld_t7", StT7, MDO | GRA | RI, 5'd0, 1'b1); cyc(1'b0, 1'b1, 1'b0);
      ir = IR_SUB;
      exp_idle("ld_idle");    cyc(1'b1, 1'b1, 1'b0);

      // ALU op then ldi back to back with run held high
      fetch("sub", 1'b1);
      exp_run("sub_t3", StT3, GRB | RO | YI, 5'd0, 1'b0);  cyc(1'b1, 1'b1, 1'b0);
      ir = IR_LDI;
      exp_run("sub_t4", StT4, GRC | RO | ZI, 5'd4, 1'b0);  cyc(1'b1, 1'b1, 1'b0);
      exp_run("sub_t5", StT5, ZLO | GRA | RI, 5'd0, 1'b1); cyc(1'b1, 1'b1, 1'b0);
      fetch("ldi", 1'b1);
      exp_run("ldi_t3", StT3, GRB | BAO | YI, 5'd0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
      exp_run("ldi_t4", StT4, CO | ZI, 5'd3, 1'b0);        cyc(1'b1, 1'b1, 1'b0);
      exp_run("ldi_t5", StT5, ZLO | GRA | RI, 5'd0, 1'b1); cyc(1'b0, 1'b1, 1'b0);
      ir = IR_NOP;
      exp_idle("ldi_idle");   cyc(1'b1, 1'b1, 1'b0);

      // unassigned opcode: done in T3 only
      fetch("nop", 1'b0);
      exp_run("nop_t3", StT3, NONE, 5'd0, 1'b1); cyc(1'b0, 1'b1, 1'b0);
`ifdef SEQ_MEM_WAIT_EN
      ir = IR_ST;
      exp_idle("nop_idle");   cyc(1'b1, 1'b1, 1'b0);
      // st with three wait cycles in T7; mem_ready low in T6 must be ignored
      fetch("st", 1'b0);
      exp_run("st_t3", StT3, GRB | BAO | YI, 5'd0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
      exp_run("st_t4", StT4, CO | ZI, 5'd3, 1'b0);        cyc(1'b0, 1'b1, 1'b0);
      exp_run("st_t5", StT5, ZLO | MAI, 5'd0, 1'b0);      cyc(1'b0, 1'b1, 1'b0);
      exp_run("st_t6", StT6, GRA | RO | MDI, 5'd0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         exp_run("st_t7_wait", StT7, WR, 5'd0, 1'b0);     cyc(1'b0, 1'b0, 1'b0);
      end
      exp_run("st_t7_done", StT7, WR, 5'd0, 1'b1);       cyc(1'b0, 1'b1, 1'b0);
      ir = IR_LD;
      exp_idle("st_idle");    cyc(1'b1, 1'b1, 1'b0);
`else
      ir = IR_LD;
      exp_idle("nop_idle");   cyc(1'b1, 1'b0, 1'b0);
      // fixed-latency memory: mem_ready low throughout still completes in 8 cycles
      exp_run("ldf_t0", StT0, PCO | MAI | INC | ZI, 5'd0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t1", StT1, ZLO | PCI | RD | MDI, 5'd0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t2", StT2, MDO | IRI, 5'd0, 1'b0);            cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t3", StT3, GRB | BAO | YI, 5'd0, 1'b0);       cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t4", StT4, CO | ZI, 5'd3, 1'b0);              cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t5", StT5, ZLO | MAI, 5'd0, 1'b0);            cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t6", StT6, RD | MDI, 5'd0, 1'b0);             cyc(1'b0, 1'b0, 1'b0);
      exp_run("ldf_t7", StT7, MDO | GRA | RI, 5'd0, 1'b1);       cyc(1'b0, 1'b0, 1'b0);
      exp_idle("ldf_idle");   cyc(1'b1, 1'b1, 1'b0);
`endif

      // clear raised in ld T6 while memory is not ready
      fetch("ldc", 1'b0);
      exp_run("ldc_t3", StT3, GRB | BAO | YI, 5'd0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
      exp_run("ldc_t4", StT4, CO | ZI, 5'd3, 1'b0);        cyc(1'b0, 1'b1, 1'b0);
      exp_run("ldc_t5", StT5, ZLO | MAI, 5'd0, 1'b0);      cyc(1'b0, 1'b1, 1'b0);
      exp_run("ldc_t6", StT6, RD | MDI, 5'd0, 1'b0);       cyc(1'b0, 1'b0, 1'b1);
      ir = IR_HALT;
      exp_idle("clear_mid_wait"); cyc(1'b1, 1'b1, 1'b0);

      // halt: sticky until clear, run toggling ignored
      fetch("halt", 1'b0);
      exp_run("halt_t3", StT3, NONE, 5'd0, 1'b1); cyc(1'b1, 1'b1, 1'b0);
      exp_halt("halted_0");       cyc(1'b0, 1'b1, 1'b0);
      exp_halt("halted_1");       cyc(1'b1, 1'b1, 1'b0);
      exp_halt("halted_2");       cyc(1'b0, 1'b1, 1'b0);
      exp_halt("halted_3");       cyc(1'b1, 1'b1, 1'b1);
      exp_idle("halt_cleared");   cyc(1'b0, 1'b1, 1'b0);
      exp_idle("idle_after_halt"); cyc(1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
